id_ex_operand_stage: RTL and testbench
======================================

Name: id_ex_operand_stage

Overview:
- ID/EX pipeline stage of the 5-stage RISC-V core.
- Consumes the register-file read data, resolves operand hazards by forwarding from EX, MEM and WB, and detects load-use hazards, stalling for one cycle.
- Registers the decoded instruction into the ID/EX latch that feeds EX.
- Absorbs pipeline hold and branch flush.

Parameters:
- DW, 32, datapath width.
- AW, 5, register address width.
- CW, 16, width of the opaque decoded-control bundle passed to EX.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- id_valid  in  1  ID holds a real instruction.
- id_pc  in  DW  PC of the ID instruction.
- id_rs1, id_rs2  in  AW  source register indices.
- id_use_rs1, id_use_rs2  in  1  instruction actually reads rs1/rs2.
- id_rd  in  AW  destination index.
- id_regwrite  in  1  instruction writes rd.
- id_mem_read  in  1  instruction is a load.
- id_imm  in  DW  decoded immediate.
- id_ctrl  in  CW  decoded control bundle.
- id_rd1, id_rd2  in  DW  RF read data for rs1/rs2 (x0 already reads 0).
- ex_alu_result  in  DW  combinational EX result of the instruction currently in this latch.
- mem_rd  in  AW  EX/MEM destination.
- mem_regwrite  in  1  EX/MEM writes rd.
- mem_wdata  in  DW  EX/MEM final writeback value (load data already merged).
- wb_rd  in  AW  MEM/WB destination.
- wb_regwrite  in  1  MEM/WB writes rd.
- wb_wdata  in  DW  MEM/WB writeback value.
- hold  in  1  external pipeline freeze (memory wait).
- flush  in  1  branch/jump taken in EX; kill the ID instruction.
- stall  out  1  freeze PC and IF/ID this cycle.
- ex_valid  out  1  latch holds a real instruction.
- ex_pc  out  DW
- ex_rs1_val, ex_rs2_val  out  DW  forwarded operands.
- ex_imm  out  DW
- ex_rd  out  AW
- ex_regwrite  out  1
- ex_mem_read  out  1
- ex_ctrl  out  CW

Behaviour:
- Reset: synchronous on rst=1 at the rising clk edge. All ex_* outputs go to 0. stall is combinational and evaluates to 0 because the latch is invalid.
- Hazard match: a source is "hit" by a stage when all of the following hold:
  - use_rsX=1;
  - rsX!=0;
  - the stage's rd equals rsX;
  - the stage's regwrite=1 (the EX stage additionally requires ex_valid=1).
- Operand select per source, first match wins:
  - EX hit with ex_mem_read=0 -> ex_alu_result.
  - MEM hit -> mem_wdata.
  - WB hit -> wb_wdata (see Optional Feature).
  - Otherwise -> id_rdX.
- Load-use hazard: lu = id_valid & EX hit (either source) & ex_mem_read.
- stall = (lu | hold) & ~flush.
- Latch update at the rising edge, priority highest first:
  - rst: clear.
  - flush: bubble (ex_valid=0, ex_regwrite=0, ex_mem_read=0, ex_ctrl=0; data fields don't-care but cleared to 0).
  - hold: keep all contents unchanged.
  - lu: insert bubble, same clearing as flush.
  - Otherwise: capture the ID fields and the forwarded operands. ex_valid=id_valid; ex_regwrite and ex_mem_read are gated by id_valid.
- Latency: one cycle from ID inputs to ex_* outputs. A load-use hazard costs exactly one bubble; the next cycle the load is in MEM, so the MEM path supplies the data and stall drops.
- Simultaneous events:
  - flush+lu -> bubble, stall=0.
  - flush+hold -> bubble, stall=0.
  - hold+lu -> latch held, stall=1; lu is re-evaluated after hold releases.
- rd=0 is never a forwarding source, even when its regwrite=1.
- No arithmetic; all widths pass through unchanged.

Optional Feature:
- Macro: FWD_WB_EN.
- Defined: the WB hit path selects wb_wdata.
- Undefined: the WB path is omitted and the value comes from id_rdX. This is legal because the RF writes on the falling edge and reads combinationally, so the value is already visible before the capturing rising edge.
- Both builds must produce identical ex_rs*_val for any legal sequence.

Test Plan:
- Reset: assert rst for 2 cycles with id_valid=1 -> every ex_* is 0 and stall=0 throughout.
- EX forward: latch holds addi x5 (ex_alu_result=0x11); ID has add x6,x5,x0 with id_rd1=0xDEAD -> next cycle ex_rs1_val=0x11.
- MEM priority: mem_rd=7 with mem_wdata=0x22, and wb_rd=7 with wb_wdata=0x33; ID uses rs2=7 -> ex_rs2_val=0x22. With rs2=0 and the same stage values -> ex_rs2_val=0.
- Load-use: latch holds lw x8 (ex_mem_read=1); ID has add x9,x8,x8 -> stall=1 for exactly one cycle and a bubble is inserted (ex_valid=0). Next cycle, with mem_rd=8 and mem_wdata=0x44 -> ex_rs1_val=ex_rs2_val=0x44 and stall=0.
- Flush priority: raise flush together with a load-use condition -> stall=0 and ex_valid=0 next cycle. Raise flush together with hold -> bubble; contents are not held.
- Hold: hold=1 for 3 cycles while ID inputs change -> ex_* stay constant, stall=1. Release -> the current ID instruction is captured.

Source files
------------

// File: rtl/id_ex_operand_stage_if.sv
// ID/EX operand stage bus: ID-side instruction fields, EX/MEM/WB forwarding
// sources, pipeline control, and the ID/EX latch outputs feeding EX.
interface id_ex_operand_stage_if #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 5,
    parameter int unsigned CW = 16
);
    logic          id_valid;
    logic [DW-1:0] id_pc;
    logic [AW-1:0] id_rs1;
    logic [AW-1:0] id_rs2;
    logic          id_use_rs1;
    logic          id_use_rs2;
    logic [AW-1:0] id_rd;
    logic          id_regwrite;
    logic          id_mem_read;
    logic [DW-1:0] id_imm;
    logic [CW-1:0] id_ctrl;
    logic [DW-1:0] id_rd1;
    logic [DW-1:0] id_rd2;
    logic [DW-1:0] ex_alu_result;
    logic [AW-1:0] mem_rd;
    logic          mem_regwrite;
    logic [DW-1:0] mem_wdata;
    logic [AW-1:0] wb_rd;
    logic          wb_regwrite;
    logic [DW-1:0] wb_wdata;
    logic          hold;
    logic          flush;
    logic          stall;
    logic          ex_valid;
    logic [DW-1:0] ex_pc;
    logic [DW-1:0] ex_rs1_val;
    logic [DW-1:0] ex_rs2_val;
    logic [DW-1:0] ex_imm;
    logic [AW-1:0] ex_rd;
    logic          ex_regwrite;
    logic          ex_mem_read;
    logic [CW-1:0] ex_ctrl;

    // Pipeline side: drives ID fields and forwarding sources, observes the latch.
    modport master (
        output id_valid, id_pc, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
               id_regwrite, id_mem_read, id_imm, id_ctrl, id_rd1, id_rd2,
               ex_alu_result, mem_rd, mem_regwrite, mem_wdata,
               wb_rd, wb_regwrite, wb_wdata, hold, flush,
        input  stall, ex_valid, ex_pc, ex_rs1_val, ex_rs2_val, ex_imm, ex_rd,
               ex_regwrite, ex_mem_read, ex_ctrl
    );

    // Operand stage side.
    modport slave (
        input  id_valid, id_pc, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
               id_regwrite, id_mem_read, id_imm, id_ctrl, id_rd1, id_rd2,
               ex_alu_result, mem_rd, mem_regwrite, mem_wdata,
               wb_rd, wb_regwrite, wb_wdata, hold, flush,
        output stall, ex_valid, ex_pc, ex_rs1_val, ex_rs2_val, ex_imm, ex_rd,
               ex_regwrite, ex_mem_read, ex_ctrl
    );
endinterface

// File: rtl/id_ex_operand_stage.sv
// ID/EX operand stage: forwards EX/MEM(/WB) results onto the register-file
// operands, detects load-use hazards (one bubble), and registers the decoded
// instruction into the ID/EX latch. Absorbs hold and branch flush.
// Optional macro FWD_WB_EN adds the WB forwarding path; without it the RF's
// write-before-read timing already presents the WB value on id_rd1/id_rd2.
module id_ex_operand_stage #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 5,
    parameter int unsigned CW = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    id_ex_operand_stage_if.slave bus
);

    logic          ex_valid_q,    ex_valid_d;
    logic [DW-1:0] ex_pc_q,       ex_pc_d;
    logic [DW-1:0] ex_rs1_val_q,  ex_rs1_val_d;
    logic [DW-1:0] ex_rs2_val_q,  ex_rs2_val_d;
    logic [DW-1:0] ex_imm_q,      ex_imm_d;
    logic [AW-1:0] ex_rd_q,       ex_rd_d;
    logic          ex_regwrite_q, ex_regwrite_d;
    logic          ex_mem_read_q, ex_mem_read_d;
    logic [CW-1:0] ex_ctrl_q,     ex_ctrl_d;

    logic          ex_hit1, ex_hit2, mem_hit1, mem_hit2;
    logic          load_use;
    logic [DW-1:0] rs1_fwd, rs2_fwd;

    function automatic logic src_hit(input logic use_rs, input logic [AW-1:0] rs,
                                     input logic [AW-1:0] rd, input logic we);
        return use_rs && (rs != '0) && (rd == rs) && we;
    endfunction

    assign ex_hit1  = src_hit(bus.id_use_rs1, bus.id_rs1, ex_rd_q, ex_regwrite_q && ex_valid_q);
    assign ex_hit2  = src_hit(bus.id_use_rs2, bus.id_rs2, ex_rd_q, ex_regwrite_q && ex_valid_q);
    assign mem_hit1 = src_hit(bus.id_use_rs1, bus.id_rs1, bus.mem_rd, bus.mem_regwrite);
    assign mem_hit2 = src_hit(bus.id_use_rs2, bus.id_rs2, bus.mem_rd, bus.mem_regwrite);

    assign load_use  = bus.id_valid && (ex_hit1 || ex_hit2) && ex_mem_read_q;
    assign bus.stall = (load_use || bus.hold) && !bus.flush;

`ifdef FWD_WB_EN
    logic wb_hit1, wb_hit2;
    assign wb_hit1 = src_hit(bus.id_use_rs1, bus.id_rs1, bus.wb_rd, bus.wb_regwrite);
    assign wb_hit2 = src_hit(bus.id_use_rs2, bus.id_rs2, bus.wb_rd, bus.wb_regwrite);
`else
    logic unused_wb;
    assign unused_wb = ^{bus.wb_rd, bus.wb_regwrite, bus.wb_wdata};
`endif

    // Operand select: youngest producer wins, a load still in EX cannot forward.
    always_comb begin
        rs1_fwd = bus.id_rd1;
        rs2_fwd = bus.id_rd2;
        if (ex_hit1 && !ex_mem_read_q) rs1_fwd = bus.ex_alu_result;
        else if (mem_hit1)             rs1_fwd = bus.mem_wdata;
`ifdef FWD_WB_EN
        else if (wb_hit1)              rs1_fwd = bus.wb_wdata;
`endif
        if (ex_hit2 && !ex_mem_read_q) rs2_fwd = bus.ex_alu_result;
        else if (mem_hit2)             rs2_fwd = bus.mem_wdata;
`ifdef FWD_WB_EN
        else if (wb_hit2)              rs2_fwd = bus.wb_wdata;
`endif
    end

    // Latch next state: flush > hold > load-use bubble > capture.
    always_comb begin
        ex_valid_d    = ex_valid_q;
        ex_pc_d       = ex_pc_q;
        ex_rs1_val_d  = ex_rs1_val_q;
        ex_rs2_val_d  = ex_rs2_val_q;
        ex_imm_d      = ex_imm_q;
        ex_rd_d       = ex_rd_q;
        ex_regwrite_d = ex_regwrite_q;
        ex_mem_read_d = ex_mem_read_q;
        ex_ctrl_d     = ex_ctrl_q;
        if (bus.flush || (!bus.hold && load_use)) begin
            ex_valid_d    = 1'b0;
            ex_pc_d       = '0;
            ex_rs1_val_d  = '0;
            ex_rs2_val_d  = '0;
            ex_imm_d      = '0;
            ex_rd_d       = '0;
            ex_regwrite_d = 1'b0;
            ex_mem_read_d = 1'b0;
            ex_ctrl_d     = '0;
        end else if (!bus.hold) begin
            ex_valid_d    = bus.id_valid;
            ex_pc_d       = bus.id_pc;
            ex_rs1_val_d  = rs1_fwd;
            ex_rs2_val_d  = rs2_fwd;
            ex_imm_d      = bus.id_imm;
            ex_rd_d       = bus.id_rd;
            ex_regwrite_d = bus.id_valid && bus.id_regwrite;
            ex_mem_read_d = bus.id_valid && bus.id_mem_read;
            ex_ctrl_d     = bus.id_ctrl;
        end
    end

    // ID/EX latch register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_q    <= 1'b0;
            ex_pc_q       <= '0;
            ex_rs1_val_q  <= '0;
            ex_rs2_val_q  <= '0;
            ex_imm_q      <= '0;
            ex_rd_q       <= '0;
            ex_regwrite_q <= 1'b0;
            ex_mem_read_q <= 1'b0;
            ex_ctrl_q     <= '0;
        end else begin
            ex_valid_q    <= ex_valid_d;
            ex_pc_q       <= ex_pc_d;
            ex_rs1_val_q  <= ex_rs1_val_d;
            ex_rs2_val_q  <= ex_rs2_val_d;
            ex_imm_q      <= ex_imm_d;
            ex_rd_q       <= ex_rd_d;
            ex_regwrite_q <= ex_regwrite_d;
            ex_mem_read_q <= ex_mem_read_d;
            ex_ctrl_q     <= ex_ctrl_d;
        end
    end

    assign bus.ex_valid    = ex_valid_q;
    assign bus.ex_pc       = ex_pc_q;
    assign bus.ex_rs1_val  = ex_rs1_val_q;
    assign bus.ex_rs2_val  = ex_rs2_val_q;
    assign bus.ex_imm      = ex_imm_q;
    assign bus.ex_rd       = ex_rd_q;
    assign bus.ex_regwrite = ex_regwrite_q;
    assign bus.ex_mem_read = ex_mem_read_q;
    assign bus.ex_ctrl     = ex_ctrl_q;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Bench for id_ex_operand_stage: directed scenarios plus randomized traffic
// checked against a behavioural model of the ID/EX latch and forwarding.
module tb_id_ex_operand_stage;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    id_ex_operand_stage_if bus ();

    id_ex_operand_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic        rw;
        logic        mr;
        logic [15:0] ctrl;
    } lat_t;

    lat_t m;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Architectural operand: newest in-flight producer of rs that has a value ready.
    function automatic logic [31:0] model_opnd(input logic use_rs, input logic [4:0] rs,
                                               input logic [31:0] rf);
        logic [4:0]  prd [3];
        logic        pok [3];
        logic [31:0] pv  [3];
        prd = '{m.rd, bus.mem_rd, bus.wb_rd};
        pok = '{m.valid && m.rw && !m.mr, bus.mem_regwrite, bus.wb_regwrite};
        pv  = '{bus.ex_alu_result, bus.mem_wdata, bus.wb_wdata};
        if (use_rs && rs != 5'd0)
            for (int i = 0; i < 3; i++)
                if (pok[i] && prd[i] == rs) return pv[i];
        return rf;
    endfunction

    function automatic logic model_lu();
        logic dep;
        dep = (bus.id_use_rs1 && bus.id_rs1 != 5'd0 && bus.id_rs1 == m.rd) ||
              (bus.id_use_rs2 && bus.id_rs2 != 5'd0 && bus.id_rs2 == m.rd);
        return bus.id_valid && m.valid && m.rw && m.mr && dep;
    endfunction

    // One clock: check stall mid-cycle, advance the model, check the latch.
    task automatic step();
        lat_t nxt;
        logic lu;
        @(negedge clk);
        lu = model_lu();
        check("stall", 64'(bus.stall), 64'((lu || bus.hold) && !bus.flush));
        if (rst || bus.flush || (lu && !bus.hold)) nxt = '0;
        else if (bus.hold) nxt = m;
        else begin
            nxt.valid = bus.id_valid;
            nxt.pc    = bus.id_pc;
            nxt.rs1   = model_opnd(bus.id_use_rs1, bus.id_rs1, bus.id_rd1);
            nxt.rs2   = model_opnd(bus.id_use_rs2, bus.id_rs2, bus.id_rd2);
            nxt.imm   = bus.id_imm;
            nxt.rd    = bus.id_rd;
            nxt.rw    = bus.id_valid && bus.id_regwrite;
            nxt.mr    = bus.id_valid && bus.id_mem_read;
            nxt.ctrl  = bus.id_ctrl;
        end
        @(posedge clk);
        #1;
        m = nxt;
        check("ex_valid",    64'(bus.ex_valid),    64'(m.valid));
        check("ex_pc",       64'(bus.ex_pc),       64'(m.pc));
        check("ex_rs1_val",  64'(bus.ex_rs1_val),  64'(m.rs1));
        check("ex_rs2_val",  64'(bus.ex_rs2_val),  64'(m.rs2));
        check("ex_imm",      64'(bus.ex_imm),      64'(m.imm));
        check("ex_rd",       64'(bus.ex_rd),       64'(m.rd));
        check("ex_regwrite", 64'(bus.ex_regwrite), 64'(m.rw));
        check("ex_mem_read", 64'(bus.ex_mem_read), 64'(m.mr));
        check("ex_ctrl",     64'(bus.ex_ctrl),     64'(m.ctrl));
    endtask

    task automatic id_clear();
        bus.id_valid = 1'b0;   bus.id_pc = '0;        bus.id_rs1 = '0;
        bus.id_rs2 = '0;       bus.id_use_rs1 = 1'b0; bus.id_use_rs2 = 1'b0;
        bus.id_rd = '0;        bus.id_regwrite = 1'b0; bus.id_mem_read = 1'b0;
        bus.id_imm = '0;       bus.id_ctrl = '0;      bus.id_rd1 = '0;
        bus.id_rd2 = '0;       bus.ex_alu_result = '0; bus.mem_rd = '0;
        bus.mem_regwrite = 1'b0; bus.mem_wdata = '0;  bus.wb_rd = '0;
        bus.wb_regwrite = 1'b0;  bus.wb_wdata = '0;   bus.hold = 1'b0;
        bus.flush = 1'b0;
    endtask

    // Legal random traffic: RF reads of x0 are 0, WB writes are visible to RF reads.
    task automatic drive_rand();
        bus.id_valid      = ($urandom_range(0, 9) < 8);
        bus.id_pc         = $urandom;
        bus.id_rs1        = 5'($urandom_range(0, 3));
        bus.id_rs2        = 5'($urandom_range(0, 3));
        bus.id_use_rs1    = 1'($urandom_range(0, 1));
        bus.id_use_rs2    = 1'($urandom_range(0, 1));
        bus.id_rd         = 5'($urandom_range(0, 3));
        bus.id_regwrite   = ($urandom_range(0, 9) < 7);
        bus.id_mem_read   = ($urandom_range(0, 9) < 3);
        bus.id_imm        = $urandom;
        bus.id_ctrl       = 16'($urandom);
        bus.id_rd1        = $urandom;
        bus.id_rd2        = $urandom;
        bus.ex_alu_result = $urandom;
        bus.mem_rd        = 5'($urandom_range(0, 3));
        bus.mem_regwrite  = 1'($urandom_range(0, 1));
        bus.mem_wdata     = $urandom;
        bus.wb_rd         = 5'($urandom_range(0, 3));
        bus.wb_regwrite   = 1'($urandom_range(0, 1));
        bus.wb_wdata      = $urandom;
        bus.hold          = ($urandom_range(0, 99) < 15);
        bus.flush         = ($urandom_range(0, 99) < 10);
        if (bus.id_rs1 == 5'd0) bus.id_rd1 = '0;
        if (bus.id_rs2 == 5'd0) bus.id_rd2 = '0;
        if (bus.wb_regwrite && bus.wb_rd != 5'd0 && bus.wb_rd == bus.id_rs1) bus.id_rd1 = bus.wb_wdata;
        if (bus.wb_regwrite && bus.wb_rd != 5'd0 && bus.wb_rd == bus.id_rs2) bus.id_rd2 = bus.wb_wdata;
    endtask

    initial begin
        // Reset with a live ID instruction present.
        id_clear();
        rst = 1'b1;
        bus.id_valid = 1'b1; bus.id_pc = 32'h40; bus.id_rd = 5'd3;
        bus.id_regwrite = 1'b1; bus.id_ctrl = 16'hBEEF; bus.id_imm = 32'h7;
        @(posedge clk);
        #1;
        m = '0;
        step();
        check("reset_ex_valid", 64'(bus.ex_valid), 64'd0);
        check("reset_ex_ctrl",  64'(bus.ex_ctrl),  64'd0);
        rst = 1'b0;

        // EX forward: addi x5 in latch, add x6,x5,x0 in ID.
        id_clear();
        bus.id_valid = 1'b1; bus.id_rd = 5'd5; bus.id_regwrite = 1'b1; bus.id_pc = 32'h100;
        step();
        id_clear();
        bus.id_valid = 1'b1; bus.id_rs1 = 5'd5; bus.id_use_rs1 = 1'b1; bus.id_use_rs2 = 1'b1;
        bus.id_rd = 5'd6; bus.id_regwrite = 1'b1; bus.id_rd1 = 32'hDEAD; bus.ex_alu_result = 32'h11;
        step();
        check("ex_fwd_rs1", 64'(bus.ex_rs1_val), 64'h11);

        // MEM beats WB; x0 never forwards.
        id_clear();
        bus.id_valid = 1'b1; bus.id_rs2 = 5'd7; bus.id_use_rs2 = 1'b1; bus.id_rd2 = 32'h33;
        bus.mem_rd = 5'd7; bus.mem_regwrite = 1'b1; bus.mem_wdata = 32'h22;
        bus.wb_rd = 5'd7; bus.wb_regwrite = 1'b1; bus.wb_wdata = 32'h33;
        step();
        check("mem_prio_rs2", 64'(bus.ex_rs2_val), 64'h22);
        bus.id_rs2 = 5'd0; bus.id_rd2 = '0; bus.mem_rd = 5'd0; bus.wb_rd = 5'd0;
        step();
        check("x0_rs2", 64'(bus.ex_rs2_val), 64'h0);

        // Load-use: lw x8 then add x9,x8,x8.
        id_clear();
        bus.id_valid = 1'b1; bus.id_rd = 5'd8; bus.id_regwrite = 1'b1; bus.id_mem_read = 1'b1;
        step();
        id_clear();
        bus.id_valid = 1'b1; bus.id_rs1 = 5'd8; bus.id_rs2 = 5'd8; bus.id_use_rs1 = 1'b1;
        bus.id_use_rs2 = 1'b1; bus.id_rd = 5'd9; bus.id_regwrite = 1'b1;
        bus.id_rd1 = 32'hBAD; bus.id_rd2 = 32'hBAD; bus.ex_alu_result = 32'hBAD;
        #1;
        check("lu_stall", 64'(bus.stall), 64'd1);
        step();
        check("lu_bubble", 64'(bus.ex_valid), 64'd0);
        bus.mem_rd = 5'd8; bus.mem_regwrite = 1'b1; bus.mem_wdata = 32'h44;
        #1;
        check("lu_release_stall", 64'(bus.stall), 64'd0);
        step();
        check("lu_rs1", 64'(bus.ex_rs1_val), 64'h44);
        check("lu_rs2", 64'(bus.ex_rs2_val), 64'h44);

        // Flush overrides load-use.
        id_clear();
        bus.id_valid = 1'b1; bus.id_rd = 5'd8; bus.id_regwrite = 1'b1; bus.id_mem_read = 1'b1;
        step();
        id_clear();
        bus.id_valid = 1'b1; bus.id_rs1 = 5'd8; bus.id_use_rs1 = 1'b1; bus.flush = 1'b1;
        #1;
        check("flush_lu_stall", 64'(bus.stall), 64'd0);
        step();
        check("flush_lu_valid", 64'(bus.ex_valid), 64'd0);

        // Hold freezes the latch while ID changes; release captures current ID.
        id_clear();
        bus.id_valid = 1'b1; bus.id_pc = 32'h100; bus.id_rd = 5'd4; bus.id_regwrite = 1'b1;
        step();
        for (int i = 0; i < 3; i++) begin
            drive_rand();
            bus.hold = 1'b1; bus.flush = 1'b0; bus.id_pc = 32'h200 + 32'(i);
            #1;
            check("hold_stall", 64'(bus.stall), 64'd1);
            step();
            check("hold_pc", 64'(bus.ex_pc), 64'h100);
        end
        id_clear();
        bus.id_valid = 1'b1; bus.id_pc = 32'h300;
        step();
        check("hold_release_pc", 64'(bus.ex_pc), 64'h300);
        check("hold_release_valid", 64'(bus.ex_valid), 64'd1);

        // Flush overrides hold.
        bus.hold = 1'b1; bus.flush = 1'b1;
        #1;
        check("flush_hold_stall", 64'(bus.stall), 64'd0);
        step();
        check("flush_hold_valid", 64'(bus.ex_valid), 64'd0);
        check("flush_hold_pc", 64'(bus.ex_pc), 64'd0);

        // Randomized traffic against the model.
        for (int n = 0; n < 600; n++) begin
            drive_rand();
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
